// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: DIGIT bits per cycle, MSB slice first, early exit on first unequal slice.
// Optional `CMP_SIGNED_EN adds an sgn port for two's-complement compare via offset-binary mapping at capture.

module serial_magnitude_comparator_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] da_i,
  input  logic [DIGIT-1:0] db_i,
  output logic             lt_o,
  output logic             gt_o
);
  assign lt_o = (da_i < db_i);
  assign gt_o = (da_i > db_i);
endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic             alb,
  output logic             aeb,
  output logic             agb
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             alb_q, alb_d, aeb_q, aeb_d, agb_q, agb_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] msk;
  logic             slt, sgt;

  // Flipping the sign bit of both operands turns a signed order into an unsigned one.
`ifdef CMP_SIGNED_EN
  assign msk = {sgn, {(WIDTH-1){1'b0}}};
`else
  assign msk = '0;
`endif

  serial_magnitude_comparator_slice #(.DIGIT(DIGIT)) u_slice (
    .da_i (sa_q[WIDTH-1 -: DIGIT]),
    .db_i (sb_q[WIDTH-1 -: DIGIT]),
    .lt_o (slt),
    .gt_o (sgt)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    alb_d   = alb_q;
    aeb_d   = aeb_q;
    agb_d   = agb_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a ^ msk;
          sb_d    = b ^ msk;
          cnt_d   = '0;
          alb_d   = 1'b0;
          aeb_d   = 1'b0;
          agb_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (slt) begin
          alb_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (sgt) begin
          agb_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          aeb_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      alb_q   <= 1'b0;
      aeb_q   <= 1'b0;
      agb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      alb_q   <= alb_d;
      aeb_q   <= aeb_d;
      agb_q   <= agb_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign alb  = alb_q;
  assign aeb  = aeb_q;
  assign agb  = agb_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (WIDTH=16, DIGIT=4): vector table plus handshake corner cases.
module tb_serial_magnitude_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        sgn = 1'b0;
  logic        busy, done, alb, aeb, agb;
  int          tests = 0, fails = 0;

  localparam logic [2:0] LT = 3'b100, EQ = 3'b010, GT = 3'b001;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [2:0]  flg;
  } vec_t;

  vec_t vecs[8];

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef CMP_SIGNED_EN
    .sgn   (sgn),
`endif
    .busy  (busy),
    .done  (done),
    .alb   (alb),
    .aeb   (aeb),
    .agb   (agb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive a request just after an edge; it is accepted at the next rising edge (E0).
  task automatic issue(input logic [15:0] va, input logic [15:0] vb);
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 1);
    chk("flags_after_accept", {29'd0, alb, aeb, agb}, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      chk("flags_while_busy", {29'd0, alb, aeb, agb}, 0);
    end
  endtask

  task automatic run_vec(input string nm, input logic [15:0] va, input logic [15:0] vb,
                         input int elat, input logic [2:0] eflg);
    int lat;
    issue(va, vb);
    wait_done(lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_flags"}, {29'd0, alb, aeb, agb}, {29'd0, eflg});
    chk({nm, "_busy_at_done"}, {31'd0, busy}, 0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, {31'd0, done}, 0);
    chk({nm, "_flags_hold"}, {29'd0, alb, aeb, agb}, {29'd0, eflg});
  endtask

  initial begin
    int lat, ndone;
    vecs[0] = '{16'h1234, 16'h1235, 4, LT};
    vecs[1] = '{16'hA000, 16'h1FFF, 1, GT};
    vecs[2] = '{16'hBEEF, 16'hBEEF, 4, EQ};
    vecs[3] = '{16'h0001, 16'h0002, 4, LT};
    vecs[4] = '{16'h1200, 16'h1300, 2, LT};
    vecs[5] = '{16'h1240, 16'h1230, 3, GT};
    vecs[6] = '{16'hFFFF, 16'h0000, 1, GT};
    vecs[7] = '{16'h0000, 16'h0000, 4, EQ};

    #12;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_flags", {29'd0, alb, aeb, agb}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].flg);

    // Back-to-back: new start issued in the done cycle.
    issue(16'hBEEF, 16'hBEEF);
    wait_done(lat);
    chk("b2b_first_lat", lat, 4);
    chk("b2b_first_flags", {29'd0, alb, aeb, agb}, {29'd0, EQ});
    issue(16'h0001, 16'h0002);
    wait_done(lat);
    chk("b2b_second_lat", lat, 4);
    chk("b2b_second_flags", {29'd0, alb, aeb, agb}, {29'd0, LT});
    @(posedge clk); #1;

    // Start while busy is ignored; operand changes during RUN have no effect.
    issue(16'h0001, 16'h0002);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0;
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; if (lat == 0) lat = i; end
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_lat", lat, 4);
    chk("busy_start_flags", {29'd0, alb, aeb, agb}, {29'd0, LT});

    // Reset mid-RUN aborts without a done pulse.
    issue(16'h1234, 16'h1234);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_flags", {29'd0, alb, aeb, agb}, 0);
    ndone = 0;
    repeat (4) begin @(posedge clk); #1; if (done) ndone++; end
    chk("abort_no_done", ndone, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec("post_reset", 16'h1234, 16'h1230, 4, GT);

`ifdef CMP_SIGNED_EN
    sgn = 1'b1; run_vec("sgn_m1_vs_1", 16'hFFFF, 16'h0001, 1, LT);
    sgn = 1'b0; run_vec("uns_ffff_vs_1", 16'hFFFF, 16'h0001, 1, GT);
    sgn = 1'b1; run_vec("sgn_min_vs_max", 16'h8000, 16'h7FFF, 1, LT);
    sgn = 1'b1; run_vec("sgn_eq_neg", 16'h8001, 16'h8001, 4, EQ);
    sgn = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
